// File: rtl/aes_block_packer.sv
// Packs 32-bit key/plaintext words into the AES core's Nk*32-bit key and 128-bit block inputs.
// Optional `AES_PACK_FLUSH_EN adds a synchronous flush input that discards pending data but keeps the key.
module aes_block_packer #(
    parameter int unsigned Nk = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef AES_PACK_FLUSH_EN
    input  logic               flush,
`endif
    input  logic [0:31]        din,
    input  logic               din_is_key,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [0:Nk*32-1]   key_out,
    output logic               key_loaded,
    output logic [0:127]       blk_out,
    output logic               blk_valid,
    input  logic               blk_ready
);

    localparam int unsigned KW = (Nk > 1) ? $clog2(Nk) : 1;

    logic flush_w;
`ifdef AES_PACK_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Word 0 of each packed array sits in the most significant (leftmost) slot.
    logic [0:Nk-1][0:31] key_q, key_d;
    logic [KW-1:0]       kcnt_q, kcnt_d;
    logic                key_loaded_q, key_loaded_d;
    logic [0:3][0:31]    asm_q, asm_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic                asm_full_q, asm_full_d;
    logic [0:3][0:31]    blk_q, blk_d;
    logic                blk_valid_q, blk_valid_d;
    logic                accept, complete;

    assign din_ready = !rst && !flush_w &&
                       (din_is_key ? (wcnt_q == 2'd0 && !asm_full_q && !blk_valid_q)
                                   : (key_loaded_q && !asm_full_q));
    assign accept    = din_valid && din_ready;
    assign complete  = accept && !din_is_key && (wcnt_q == 2'd3);

    always_comb begin
        key_d        = key_q;
        kcnt_d       = kcnt_q;
        key_loaded_d = key_loaded_q;
        asm_d        = asm_q;
        wcnt_d       = wcnt_q;
        asm_full_d   = asm_full_q;
        blk_d        = blk_q;
        blk_valid_d  = blk_valid_q;

        if (flush_w) begin
            wcnt_d      = '0;
            asm_full_d  = 1'b0;
            blk_valid_d = 1'b0;
        end else begin
            if (accept && din_is_key) begin
                key_d[kcnt_q] = din;
                if (kcnt_q == '0)
                    key_loaded_d = 1'b0;
                if (kcnt_q == KW'(Nk - 1)) begin
                    kcnt_d       = '0;
                    key_loaded_d = 1'b1;
                end else begin
                    kcnt_d = kcnt_q + 1'b1;
                end
            end

            if (accept && !din_is_key) begin
                asm_d[wcnt_q] = din;
                wcnt_d        = wcnt_q + 2'd1;
            end

            // A completing word can only arrive while the assembly register is empty,
            // so the drain branch never competes with a new block.
            if (complete) begin
                if (!blk_valid_q || blk_ready) begin
                    blk_d       = asm_d;
                    blk_valid_d = 1'b1;
                end else begin
                    asm_full_d = 1'b1;
                end
            end else if (blk_valid_q && blk_ready) begin
                if (asm_full_q) begin
                    blk_d      = asm_q;
                    asm_full_d = 1'b0;
                end else begin
                    blk_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q        <= '0;
            kcnt_q       <= '0;
            key_loaded_q <= 1'b0;
            asm_q        <= '0;
            wcnt_q       <= '0;
            asm_full_q   <= 1'b0;
            blk_q        <= '0;
            blk_valid_q  <= 1'b0;
        end else begin
            key_q        <= key_d;
            kcnt_q       <= kcnt_d;
            key_loaded_q <= key_loaded_d;
            asm_q        <= asm_d;
            wcnt_q       <= wcnt_d;
            asm_full_q   <= asm_full_d;
            blk_q        <= blk_d;
            blk_valid_q  <= blk_valid_d;
        end
    end

    assign key_out    = key_q;
    assign key_loaded = key_loaded_q;
    assign blk_out    = blk_q;
    assign blk_valid  = blk_valid_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Randomised and directed bench for aes_block_packer (Nk=4 and Nk=8 instances).
// A queue-based scoreboard groups accepted data words into expected blocks.
module tb_aes_block_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [0:31]  din;
    logic         din_is_key, din_valid, din_ready;
    logic [0:127] key_out;
    logic         key_loaded;
    logic [0:127] blk_out;
    logic         blk_valid, blk_ready;

    logic [0:31]  d8_din;
    logic         d8_is_key, d8_valid, d8_ready;
    logic [0:255] d8_key;
    logic         d8_loaded;
    logic [0:127] d8_blk;
    logic         d8_bvalid, d8_bready;

`ifdef AES_PACK_FLUSH_EN
    logic flush;
    logic flush8 = 1'b0;
`endif

    aes_block_packer #(.Nk(4)) u_dut (
        .clk(clk), .rst(rst),
`ifdef AES_PACK_FLUSH_EN
        .flush(flush),
`endif
        .din(din), .din_is_key(din_is_key), .din_valid(din_valid), .din_ready(din_ready),
        .key_out(key_out), .key_loaded(key_loaded),
        .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready)
    );

    aes_block_packer #(.Nk(8)) u_dut8 (
        .clk(clk), .rst(rst),
`ifdef AES_PACK_FLUSH_EN
        .flush(flush8),
`endif
        .din(d8_din), .din_is_key(d8_is_key), .din_valid(d8_valid), .din_ready(d8_ready),
        .key_out(d8_key), .key_loaded(d8_loaded),
        .blk_out(d8_blk), .blk_valid(d8_bvalid), .blk_ready(d8_bready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: every accepted data word, grouped by four, is one block in order.
    logic [31:0]  wbuf[$];
    logic [127:0] exp_q[$];
    int           blocks_seen = 0;

    always @(posedge clk) begin
        if (rst) begin
            wbuf.delete();
            exp_q.delete();
        end
`ifdef AES_PACK_FLUSH_EN
        else if (flush) begin
            wbuf.delete();
            exp_q.delete();
        end
`endif
        else begin
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_block", 0, 1);
                else begin
                    check("sb_block", blk_out, exp_q.pop_front());
                    blocks_seen++;
                end
            end
            if (din_valid && din_ready && !din_is_key) begin
                wbuf.push_back(din);
                if (wbuf.size() == 4) begin
                    exp_q.push_back({wbuf[0], wbuf[1], wbuf[2], wbuf[3]});
                    wbuf.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic k);
        int unsigned n = 0;
        din = w; din_is_key = k; din_valid = 1'b1;
        #1;
        while (!din_ready && n < 200) begin
            step();
            n++;
        end
        if (!din_ready) check("send_timeout", din_ready, 1);
        step();
        din_valid = 1'b0;
    endtask

    task automatic send8(input logic [31:0] w, input logic k);
        int unsigned n = 0;
        d8_din = w; d8_is_key = k; d8_valid = 1'b1;
        #1;
        while (!d8_ready && n < 200) begin
            step();
            n++;
        end
        if (!d8_ready) check("send8_timeout", d8_ready, 1);
        step();
        d8_valid = 1'b0;
    endtask

    logic [31:0]  kw[8];
    logic [31:0]  dw[4];
    logic [127:0] blk1, blk2, k128;
    logic [255:0] k256;
    time          t0, t1;
    int           pulses, base_seen;
    bit           done;

    initial begin
        rst = 1'b1; din = '0; din_is_key = 1'b0; din_valid = 1'b0; blk_ready = 1'b0;
        d8_din = '0; d8_is_key = 1'b0; d8_valid = 1'b0; d8_bready = 1'b0;
`ifdef AES_PACK_FLUSH_EN
        flush = 1'b0;
`endif
        #3;
        check("rst_key_out", key_out, 0);
        check("rst_key_loaded", key_loaded, 0);
        check("rst_blk_out", blk_out, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_din_ready", din_ready, 0);
        step(); step();
        rst = 1'b0;

        // T1: reset with a held block and a half-built one discards everything
        for (int unsigned i = 0; i < 4; i++) send(32'h1000_0000 + i, 1'b1);
        for (int unsigned i = 0; i < 6; i++) send($urandom, 1'b0);
        check("t1_pre_blk_valid", blk_valid, 1);
        rst = 1'b1;
        #1;
        check("t1_key_out", key_out, 0);
        check("t1_key_loaded", key_loaded, 0);
        check("t1_blk_out", blk_out, 0);
        check("t1_blk_valid", blk_valid, 0);
        step();
        rst = 1'b0; din_is_key = 1'b0; din_valid = 1'b1;
        #1;
        check("t1_data_refused", din_ready, 0);
        step();
        check("t1_key_loaded_after", key_loaded, 0);
        check("t1_data_refused2", din_ready, 0);
        din_valid = 1'b0;

        // T2: reference key and block
        send(32'h00010203, 1'b1); send(32'h04050607, 1'b1);
        send(32'h08090a0b, 1'b1); send(32'h0c0d0e0f, 1'b1);
        check("t2_key_out", key_out, 128'h000102030405060708090a0b0c0d0e0f);
        check("t2_key_loaded", key_loaded, 1);
        send(32'h00112233, 1'b0); send(32'h44556677, 1'b0); send(32'h8899aabb, 1'b0);
        din = 32'hccddeeff; din_is_key = 1'b0; din_valid = 1'b1;
        #1;
        check("t2_ready_4th", din_ready, 1);
        check("t2_valid_before", blk_valid, 0);
        step();
        din_valid = 1'b0;
        check("t2_blk_valid", blk_valid, 1);
        check("t2_blk_out", blk_out, 128'h00112233445566778899aabbccddeeff);
        blk1 = 128'h00112233445566778899aabbccddeeff;

        // T3: second block waits in assembly under backpressure
        for (int unsigned i = 0; i < 4; i++) dw[i] = $urandom;
        blk2 = {dw[0], dw[1], dw[2], dw[3]};
        for (int unsigned i = 0; i < 4; i++) send(dw[i], 1'b0);
        check("t3_din_ready_low", din_ready, 0);
        check("t3_blk_out_held", blk_out, blk1);
        check("t3_blk_valid", blk_valid, 1);
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        check("t3_blk_out_b2", blk_out, blk2);
        check("t3_blk_valid_stays", blk_valid, 1);
        check("t3_din_ready_back", din_ready, 1);
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        check("t3_drained", blk_valid, 0);

        // T4: full-rate streaming
        blk_ready = 1'b1;
        pulses = 0;
        t0 = $time;
        fork
            begin
                for (int unsigned i = 0; i < 16; i++) send($urandom, 1'b0);
                t1 = $time;
            end
            begin
                repeat (18) begin
                    step();
                    if (blk_valid) pulses++;
                end
            end
        join
        check("t4_cycles", (t1 - t0) / 10, 16);
        check("t4_pulses", pulses, 4);
        check("t4_sb_empty", exp_q.size(), 0);
        blk_ready = 1'b0;

        // T5 (Nk=4): key word refused under a pending block, then reload
        for (int unsigned i = 0; i < 4; i++) send($urandom, 1'b0);
        for (int unsigned i = 0; i < 4; i++) kw[i] = $urandom;
        k128 = {kw[0], kw[1], kw[2], kw[3]};
        din = kw[0]; din_is_key = 1'b1; din_valid = 1'b1;
        #1;
        check("t5_key_refused", din_ready, 0);
        step(); step();
        check("t5_key_loaded_kept", key_loaded, 1);
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        check("t5_key_ready_after_drain", din_ready, 1);
        step();
        din_valid = 1'b0;
        for (int unsigned i = 1; i < 4; i++) begin
            check("t5_key_loaded_low", key_loaded, 0);
            send(kw[i], 1'b1);
        end
        check("t5_key_loaded_high", key_loaded, 1);
        check("t5_key_out", key_out, k128);

        // T5 (Nk=8)
        k256 = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            kw[i] = $urandom;
            k256 = (k256 << 32) | 256'(kw[i]);
            check("t5n8_key_loaded_low", d8_loaded, 0);
            send8(kw[i], 1'b1);
        end
        check("t5n8_key_loaded", d8_loaded, 1);
        check("t5n8_key_out", d8_key, k256);
        for (int unsigned i = 0; i < 4; i++) begin
            dw[i] = $urandom;
            send8(dw[i], 1'b0);
        end
        check("t5n8_blk_out", d8_blk, {dw[0], dw[1], dw[2], dw[3]});
        d8_din = 32'hdead_beef; d8_is_key = 1'b1; d8_valid = 1'b1;
        #1;
        check("t5n8_key_refused", d8_ready, 0);
        d8_valid = 1'b0;
        d8_bready = 1'b1;
        step();
        d8_bready = 1'b0;
        check("t5n8_drained", d8_bvalid, 0);
        for (int unsigned i = 0; i < 8; i++) begin
            send8(kw[7 - i], 1'b1);
            if (i < 7) check("t5n8_reload_low", d8_loaded, 0);
        end
        check("t5n8_reload_high", d8_loaded, 1);

        // Randomised traffic with random backpressure
        base_seen = blocks_seen;
        done = 1'b0;
        fork
            begin
                for (int unsigned i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send($urandom, 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    blk_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        blk_ready = 1'b1;
        repeat (5) step();
        blk_ready = 1'b0;
        check("rand_sb_empty", exp_q.size(), 0);
        check("rand_blocks", blocks_seen - base_seen, 100);
        check("rand_idle", blk_valid, 0);

`ifdef AES_PACK_FLUSH_EN
        // T6: flush drops the held block and a partial one, keeps the key
        for (int unsigned i = 0; i < 7; i++) send($urandom, 1'b0);
        check("t6_pre_valid", blk_valid, 1);
        flush = 1'b1; din = $urandom; din_is_key = 1'b0; din_valid = 1'b1;
        #1;
        check("t6_ready_in_flush", din_ready, 0);
        step();
        flush = 1'b0; din_valid = 1'b0;
        check("t6_blk_valid", blk_valid, 0);
        check("t6_key_loaded", key_loaded, 1);
        for (int unsigned i = 0; i < 4; i++) begin
            dw[i] = $urandom;
            send(dw[i], 1'b0);
        end
        check("t6_clean_valid", blk_valid, 1);
        check("t6_clean_block", blk_out, {dw[0], dw[1], dw[2], dw[3]});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
